// File: rtl/ft600_rx_stage.sv
// FT600 245-sync receive front end: drives OE_N/RD_N, captures words into a skid buffer
// and feeds the async FIFO write port. Define FT600_RX_BE_EN to apply byte enables at capture.
module ft600_rx_stage #(
  parameter int DATA_WIDTH  = 16,
  parameter int SKID_ADDR   = 2,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   w_clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  ft_data,
  input  logic [1:0]             ft_be,
  input  logic                   ft_rxf_n,
  output logic                   ft_oe_n,
  output logic                   ft_rd_n,
  input  logic                   rx_en,
  output logic                   fifo_w_en,
  output logic [DATA_WIDTH-1:0]  fifo_w_data,
  input  logic                   fifo_w_full,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] rx_count
);

  localparam int SKID_DEPTH = 1 << SKID_ADDR;
  localparam logic [SKID_ADDR:0] LP_DEPTH = {1'b1, {SKID_ADDR{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    READ = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [DATA_WIDTH-1:0]  r_skid [SKID_DEPTH];
  logic [SKID_ADDR-1:0]   r_wrPtr;
  logic [SKID_ADDR-1:0]   r_rdPtr;
  logic [SKID_ADDR:0]     r_level;
  logic [SKID_ADDR:0]     w_levelNext;
  logic [COUNT_WIDTH-1:0] r_rxCount;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_beOk;
  logic [DATA_WIDTH-1:0]  w_capData;

`ifdef FT600_RX_BE_EN
  always_comb begin
    w_beOk    = (ft_be != 2'b00);
    w_capData = ft_data;
    if (ft_be == 2'b01) w_capData[DATA_WIDTH-1:8] = '0;
    if (ft_be == 2'b10) w_capData[7:0] = '0;
  end
`else
  logic w_unusedBe;
  assign w_unusedBe = ^ft_be;
  assign w_beOk     = 1'b1;
  assign w_capData  = ft_data;
`endif

  assign w_push      = (r_state == READ) & ~ft_rxf_n & w_beOk;
  assign w_pop       = (r_level != '0) & ~fifo_w_full;
  assign w_levelNext = r_level + {{SKID_ADDR{1'b0}}, w_push} - {{SKID_ADDR{1'b0}}, w_pop};

  // Leaving READ whenever the post-edge level would hit full keeps RD_N high before the buffer can overflow.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (rx_en && !ft_rxf_n && (r_level < LP_DEPTH)) w_stateNext = TURN;
      TURN:    w_stateNext = ft_rxf_n ? IDLE : READ;
      READ:    if (ft_rxf_n || !rx_en || !(w_levelNext < LP_DEPTH)) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_level   <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_rxCount <= '0;
    end else begin
      r_state <= w_stateNext;
      r_level <= w_levelNext;
      if (w_push) r_wrPtr <= r_wrPtr + SKID_ADDR'(1);
      if (w_pop) begin
        r_rdPtr   <= r_rdPtr + SKID_ADDR'(1);
        r_rxCount <= r_rxCount + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_push && !rst) r_skid[r_wrPtr] <= w_capData;
  end

  assign ft_oe_n     = (r_state == IDLE);
  assign ft_rd_n     = (r_state != READ);
  assign fifo_w_en   = w_pop;
  assign fifo_w_data = r_skid[r_rdPtr];
  assign busy        = (r_state != IDLE) | (r_level != '0);
  assign rx_count    = r_rxCount;

endmodule

// File: tb/tb_ft600_rx_stage.sv
// Directed bench for ft600_rx_stage: an FT600 host model feeds words, a scoreboard
// queue holds expected FIFO writes and is popped whenever the DUT writes.
module tb_ft600_rx_stage;

  logic        w_clk;
  logic        rst;
  logic [15:0] ft_data;
  logic [1:0]  ft_be;
  logic        ft_rxf_n;
  logic        ft_oe_n;
  logic        ft_rd_n;
  logic        rx_en;
  logic        fifo_w_en;
  logic [15:0] fifo_w_data;
  logic        fifo_w_full;
  logic        busy;
  logic [3:0]  rx_count;

  logic [15:0] hostData[$];
  logic [1:0]  hostBe[$];
  logic [15:0] expQ[$];
  logic        rxfAllow;
  int          nCompared;
  int          nMismatched;

  ft600_rx_stage #(.DATA_WIDTH(16), .SKID_ADDR(2), .COUNT_WIDTH(4)) dut (
    .w_clk(w_clk), .rst(rst), .ft_data(ft_data), .ft_be(ft_be), .ft_rxf_n(ft_rxf_n),
    .ft_oe_n(ft_oe_n), .ft_rd_n(ft_rd_n), .rx_en(rx_en), .fifo_w_en(fifo_w_en),
    .fifo_w_data(fifo_w_data), .fifo_w_full(fifo_w_full), .busy(busy), .rx_count(rx_count)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [1:0] be);
    hostData.push_back(d);
    hostBe.push_back(be);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge w_clk);
    #2;
  endtask

  task automatic waitIdle(input string tag, input int lim);
    int k;
    k = 0;
    while (k < lim && !(hostData.size() == 0 && expQ.size() == 0 && !busy)) begin
      tick(1);
      k++;
    end
    checkOutput(tag, 32'(k < lim), 32'd1);
  endtask

  function automatic logic beKeep(input logic [1:0] be);
`ifdef FT600_RX_BE_EN
    return be != 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [15:0] beMask(input logic [15:0] d, input logic [1:0] be);
`ifdef FT600_RX_BE_EN
    return d & {{8{be[1]}}, {8{be[0]}}};
`else
    return d;
`endif
  endfunction

  // Host side: a word leaves the FT600 on each edge where RD_N and RXF_N are both low.
  always @(posedge w_clk) begin
    logic [15:0] d;
    logic [1:0]  b;
    if (!rst && !ft_rd_n && !ft_rxf_n && hostData.size() > 0) begin
      d = hostData.pop_front();
      b = hostBe.pop_front();
      if (beKeep(b)) expQ.push_back(beMask(d, b));
    end
  end

  // Scoreboard check and host bus update, both away from the rising edge.
  always @(negedge w_clk) begin
    logic [15:0] e;
    if (!rst && fifo_w_en) begin
      if (expQ.size() == 0) begin
        checkOutput("write_expected", 32'(expQ.size()), 32'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("fifo_data", 32'(fifo_w_data), 32'(e));
      end
    end
    ft_rxf_n = !(hostData.size() > 0 && rxfAllow);
    ft_data  = (hostData.size() > 0) ? hostData[0] : 16'h0;
    ft_be    = (hostBe.size() > 0) ? hostBe[0] : 2'b11;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int  k;
    logic sawTurn;
    nCompared   = 0;
    nMismatched = 0;
    rst         = 1'b1;
    rx_en       = 1'b0;
    fifo_w_full = 1'b0;
    rxfAllow    = 1'b1;
    ft_rxf_n    = 1'b1;
    ft_data     = 16'h0;
    ft_be       = 2'b11;
    tick(2);
    checkOutput("rst_oe_n", 32'(ft_oe_n), 32'd1);
    checkOutput("rst_rd_n", 32'(ft_rd_n), 32'd1);
    checkOutput("rst_w_en", 32'(fifo_w_en), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(rx_count), 32'd0);
    rst = 1'b0;

    // Basic burst of 8 words.
    rx_en = 1'b1;
    for (int i = 1; i <= 8; i++) applyStimulus(16'(i), 2'b11);
    tick(1);
    checkOutput("turn_oe_n", 32'(ft_oe_n), 32'd0);
    checkOutput("turn_rd_n", 32'(ft_rd_n), 32'd1);
    tick(1);
    checkOutput("read_rd_n", 32'(ft_rd_n), 32'd0);
    tick(1);
    checkOutput("latency_w_en", 32'(fifo_w_en), 32'd1);
    waitIdle("burst_idle", 50);
    checkOutput("burst_count", 32'(rx_count), 32'd8);
    checkOutput("burst_busy", 32'(busy), 32'd0);

    // FIFO full: only the skid depth may be captured.
    fifo_w_full = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(16'h0100 + 16'(i), 2'b11);
    k = 0;
    while (ft_rd_n && k < 10) begin tick(1); k++; end
    checkOutput("full_read_start", 32'(k < 10), 32'd1);
    tick(3);
    checkOutput("full_rd_n_before", 32'(ft_rd_n), 32'd0);
    tick(1);
    checkOutput("full_rd_n_at4", 32'(ft_rd_n), 32'd1);
    tick(3);
    checkOutput("full_hold_rd_n", 32'(ft_rd_n), 32'd1);
    checkOutput("full_host_left", 32'(hostData.size()), 32'd6);
    checkOutput("full_busy", 32'(busy), 32'd1);
    fifo_w_full = 1'b0;
    sawTurn = 1'b0;
    k = 0;
    while (k < 60 && !(hostData.size() == 0 && expQ.size() == 0 && !busy)) begin
      tick(1);
      k++;
      if (!ft_oe_n && ft_rd_n) sawTurn = 1'b1;
    end
    checkOutput("full_resume_idle", 32'(k < 60), 32'd1);
    checkOutput("full_resume_turn", 32'(sawTurn), 32'd1);
    checkOutput("full_count_wrap", 32'(rx_count), 32'd2);

    // RXF_N toggling during the burst.
    for (int i = 0; i < 8; i++) applyStimulus(16'h0200 + 16'(i), 2'b11);
    k = 0;
    while (k < 200 && !(hostData.size() == 0 && expQ.size() == 0 && !busy)) begin
      rxfAllow = ((k % 6) < 4);
      tick(1);
      k++;
    end
    rxfAllow = 1'b1;
    checkOutput("toggle_idle", 32'(k < 200), 32'd1);
    checkOutput("toggle_count", 32'(rx_count), 32'd10);

    // Reset with two words held in the skid buffer.
    fifo_w_full = 1'b1;
    applyStimulus(16'h0300, 2'b11);
    applyStimulus(16'h0301, 2'b11);
    k = 0;
    while (hostData.size() != 0 && k < 10) begin tick(1); k++; end
    tick(2);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    fifo_w_full = 1'b0;
    expQ.delete();
    tick(1);
    checkOutput("mid_rst_oe_n", 32'(ft_oe_n), 32'd1);
    checkOutput("mid_rst_rd_n", 32'(ft_rd_n), 32'd1);
    checkOutput("mid_rst_w_en", 32'(fifo_w_en), 32'd0);
    checkOutput("mid_rst_count", 32'(rx_count), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(5);
    checkOutput("post_rst_count", 32'(rx_count), 32'd0);

    // Counter wrap: 14 then 3 more words on a 4-bit counter.
    for (int i = 0; i < 14; i++) applyStimulus(16'h0400 + 16'(i), 2'b11);
    waitIdle("wrap14_idle", 80);
    checkOutput("wrap14_count", 32'(rx_count), 32'd14);
    for (int i = 0; i < 3; i++) applyStimulus(16'h0500 + 16'(i), 2'b11);
    waitIdle("wrap17_idle", 40);
    checkOutput("wrap17_count", 32'(rx_count), 32'd1);

    // Byte enables.
    applyStimulus(16'hABCD, 2'b11);
    applyStimulus(16'hABCD, 2'b00);
    applyStimulus(16'hABCD, 2'b01);
    applyStimulus(16'hABCD, 2'b10);
    waitIdle("be_idle", 40);
`ifdef FT600_RX_BE_EN
    checkOutput("be_count", 32'(rx_count), 32'd4);
`else
    checkOutput("be_count", 32'(rx_count), 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ft600_rx_stage.md
Name: ft600_rx_stage

Overview:
- Write-side feeder for the async FIFO in the FT600 receive path. Runs in the FT600 clock domain (w_clk).
- Drives the FT600 245-synchronous read handshake (OE_N/RD_N) and captures incoming words into a small local skid buffer.
- Pushes buffered words into the async FIFO write port, obeying its w_full flag. No word is ever dropped or duplicated.

Parameters:
- DATA_WIDTH, 16, FT600 data bus width and FIFO word width.
- SKID_ADDR, 2, log2 of skid buffer depth (SKID_DEPTH = 1<<SKID_ADDR, minimum 2).
- COUNT_WIDTH, 32, width of the received-word counter.

Ports:
- w_clk  in  1  FT600 clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- ft_data  in  DATA_WIDTH  FT600 data bus, valid while ft_oe_n is low.
- ft_be  in  2  FT600 byte enables.
- ft_rxf_n  in  1  FT600 receive-data-available, active-low.
- ft_oe_n  out  1  FT600 output enable, active-low, registered.
- ft_rd_n  out  1  FT600 read strobe, active-low, registered.
- rx_en  in  1  permits new read bursts.
- fifo_w_en  out  1  async FIFO write enable.
- fifo_w_data  out  DATA_WIDTH  async FIFO write data.
- fifo_w_full  in  1  async FIFO full flag.
- busy  out  1  high when state is not IDLE or the skid buffer is not empty.
- rx_count  out  COUNT_WIDTH  words forwarded to the FIFO; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset: state=IDLE, ft_oe_n=1, ft_rd_n=1, skid level=0, skid pointers=0, rx_count=0, busy=0, fifo_w_en=0.
- Reset asserted mid-burst: the above values hold from the next edge. Skid contents are discarded.
- State machine (ft_oe_n and ft_rd_n are decoded from the registered state):
  - IDLE: oe_n=1, rd_n=1. Go to TURN when rx_en & ~ft_rxf_n & level<SKID_DEPTH.
  - TURN: oe_n=0, rd_n=1 (one cycle of bus turnaround). Go to READ if ~ft_rxf_n, else IDLE.
  - READ: oe_n=0, rd_n=0.
- Capture: a word is captured at an edge where the state is READ and ft_rxf_n is sampled 0. ft_data is written at skid[wr_ptr] and wr_ptr increments.
- READ exit and stay:
  - Stay in READ iff ~ft_rxf_n & rx_en & level_next<SKID_DEPTH. level_next includes this edge's push and pop.
  - Otherwise go to IDLE, releasing oe_n and rd_n together. This guarantees rd_n is never low while the buffer is full.
- Drain (combinational on registered state):
  - fifo_w_en = (level!=0) & ~fifo_w_full.
  - fifo_w_data = skid[rd_ptr].
  - On an edge with fifo_w_en=1: rd_ptr increments and rx_count increments.
- Level arithmetic:
  - level is SKID_ADDR+1 bits.
  - Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo SKID_DEPTH.
  - Level never exceeds SKID_DEPTH and never underflows.
- Throughput: sustained 1 word/cycle while ft_rxf_n=0 and the FIFO is not full.
- Latency: a word captured at edge k is presented on fifo_w_data/fifo_w_en during cycle k+1 (earliest write at edge k+1), when the buffer was empty before the capture.
- fifo_w_full stale-high (pessimistic) only delays draining. Correctness never depends on it deasserting promptly.
- rx_en dropped during READ: exit at the next edge. The word captured at that edge is kept.

Optional Feature:
- Macro: FT600_RX_BE_EN.
- Defined: byte enables are applied at capture.
  - ft_be==2'b00: the word is not captured (no push, no count).
  - ft_be==2'b01: bits [DATA_WIDTH-1:8] are zeroed before storage.
  - ft_be==2'b10: bits [7:0] are zeroed before storage.
  - ft_be==2'b11: the word is stored unchanged.
- Undefined: ft_be is ignored and every captured word is stored unchanged. The port remains present.

Test Plan:
- Reset, then ft_rxf_n=0, rx_en=1, 8 words 0x0001..0x0008, fifo_w_full=0 -> IDLE→TURN→READ; fifo_w_en high 8 cycles with data 0x0001..0x0008 in order; rx_count=8; busy=0 afterwards.
- fifo_w_full held 1, 10 words available -> exactly 4 captured (depth 4); ft_rd_n high from the edge level reaches 4; release full -> 4 words out, then a new burst resumes via TURN.
- ft_rxf_n toggles 0,1,0 every 2 cycles during READ -> only cycles with rxf_n=0 captured; every rxf_n=1 returns to IDLE; no duplicate or lost words versus the model.
- rst pulsed mid-burst with 2 words buffered -> next edge ft_oe_n=1, ft_rd_n=1, fifo_w_en=0, rx_count=0; the 2 words are never written.
- rx_count preloaded near wrap (COUNT_WIDTH=4, 14 words then 3 more) -> rx_count reads 1.
- FT600_RX_BE_EN defined, be sequence 11,00,01,10 with data 0xABCD -> FIFO receives 0xABCD, 0x00CD, 0xAB00; rx_count=3.
